// File: rtl/potential_decay.sv
// potential_decay: ten-neuron leak sweep with IEEE-754 exponent decay.
// Macro POTENTIAL_DECAY_WEIGHT_CLEAR_EN makes each weight consumed on handshake.
module potential_decay (
  input  logic        CLK_Decay,
  input  logic        RST_Decay,
  input  logic        start,
  input  logic [2:0]  decay_shift,
  input  logic        weight_wr_en,
  input  logic [3:0]  weight_wr_idx,
  input  logic [31:0] weight_wr_data,
  output logic [31:0] input_weightDecay,
  output logic [31:0] decayed_potentialDecay,
  output logic [3:0]  neuron_idx,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] final_potential_in,
  input  logic        spike_in,
  output logic [9:0]  spike_vector,
  output logic        busy,
  output logic        sweep_done
);

  localparam int N = 10;
  localparam logic [3:0] LAST = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pmem [N];
  logic [31:0] wmem [N];
  logic [3:0]  idx;
  logic [2:0]  k;
  logic [9:0]  shadow;
  logic        hs;
  logic        go;
  logic        wr_ok;

  // Divide by 2^s by lowering the exponent; tiny values flush to +0.
  function automatic logic [31:0] decay(
    input logic [31:0] v,
    input logic [2:0]  s
  );
    logic [7:0] e;
    logic [7:0] ks;
    e  = v[30:23];
    ks = {5'd0, s};
    if (s == 3'd0)
      return v;
    else if (e == 8'hFF)
      return v;
    else if (e <= ks)
      return 32'h0000_0000;
    else
      return {v[31], e - ks, v[22:0]};
  endfunction

  assign hs    = out_valid & out_ready;
  assign go    = (state == IDLE) & start;
  assign wr_ok = weight_wr_en & (weight_wr_idx < 4'd10);

  assign neuron_idx             = idx;
  assign input_weightDecay      = wmem[idx];
  assign decayed_potentialDecay = decay(pmem[idx], k);

  always_ff @(posedge CLK_Decay or posedge RST_Decay) begin
    if (RST_Decay)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    out_valid  = 1'b0;
    busy       = 1'b0;
    sweep_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && idx == LAST)
          state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        sweep_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_Decay or posedge RST_Decay) begin
    if (RST_Decay) begin
      idx          <= '0;
      k            <= '0;
      shadow       <= '0;
      spike_vector <= '0;
      for (int i = 0; i < N; i++) begin
        pmem[i] <= '0;
        wmem[i] <= '0;
      end
    end else begin
      if (go) begin
        idx    <= '0;
        k      <= decay_shift;
        shadow <= '0;
      end
      if (hs) begin
        pmem[idx]   <= final_potential_in;
        shadow[idx] <= spike_in;
        idx         <= (idx == LAST) ? 4'd0 : idx + 4'd1;
`ifdef POTENTIAL_DECAY_WEIGHT_CLEAR_EN
        wmem[idx]   <= '0;
`endif
      end
      // A same-cycle host write overrides the consume-clear above.
      if (wr_ok)
        wmem[weight_wr_idx] <= weight_wr_data;
      if (state == DONE)
        spike_vector <= shadow;
    end
  end

endmodule

// File: tb/tb_potential_decay.sv
// tb_potential_decay: scoreboard bench for the potential_decay sweep.
// Expected handshakes are queued at drive time and popped by a monitor.
module tb_potential_decay;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  decay_shift;
  logic        weight_wr_en;
  logic [3:0]  weight_wr_idx;
  logic [31:0] weight_wr_data;
  logic [31:0] weight;
  logic [31:0] decayed;
  logic [3:0]  neuron_idx;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] final_potential_in;
  logic        spike_in;
  logic [9:0]  spike_vector;
  logic        busy;
  logic        sweep_done;

  potential_decay dut (
    .CLK_Decay              (clk),
    .RST_Decay              (rst),
    .start                  (start),
    .decay_shift            (decay_shift),
    .weight_wr_en           (weight_wr_en),
    .weight_wr_idx          (weight_wr_idx),
    .weight_wr_data         (weight_wr_data),
    .input_weightDecay      (weight),
    .decayed_potentialDecay (decayed),
    .neuron_idx             (neuron_idx),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .final_potential_in     (final_potential_in),
    .spike_in               (spike_in),
    .spike_vector           (spike_vector),
    .busy                   (busy),
    .sweep_done             (sweep_done)
  );

  typedef struct packed {
    logic [3:0]  i;
    logic [31:0] d;
    logic [31:0] w;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] mp [10];
  logic [31:0] mw [10];
  logic [31:0] fp [10];
  logic [9:0]  sp;
  logic [9:0]  shadow_m;
  logic [9:0]  spk_m;
  logic [2:0]  k_m;
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dm(input logic [31:0] v, input logic [2:0] s);
    int e;
    e = int'(v[30:23]);
    if (s == 0) return v;
    if (e == 255) return v;
    if (e <= int'(s)) return 32'h0;
    return {v[31], 8'(e - int'(s)), v[22:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL hs_unexpected: idx=%0d, no handshake expected", neuron_idx);
      end else begin
        mon_e = q.pop_front();
        if ({neuron_idx, decayed, weight} !== {mon_e.i, mon_e.d, mon_e.w}) begin
          failures++;
          $display("FAIL hs_idx%0d: got idx=%0d pot=%h w=%h, expected idx=%0d pot=%h w=%h",
                   mon_e.i, neuron_idx, decayed, weight, mon_e.i, mon_e.d, mon_e.w);
        end
      end
    end
  end

  task automatic wr_weight(input logic [3:0] i, input logic [31:0] d);
    weight_wr_en   = 1'b1;
    weight_wr_idx  = i;
    weight_wr_data = d;
    @(posedge clk); #1;
    weight_wr_en = 1'b0;
    if (i < 10) mw[i] = d;
  endtask

  task automatic begin_sweep(input logic [2:0] kk);
    start       = 1'b1;
    decay_shift = kk;
    @(posedge clk); #1;
    start    = 1'b0;
    shadow_m = '0;
    k_m      = kk;
  endtask

  task automatic hs_step(input int i, input logic wr, input logic [31:0] wd);
    exp_t e;
    out_ready          = 1'b1;
    final_potential_in = fp[i];
    spike_in           = sp[i];
    if (wr) begin
      weight_wr_en   = 1'b1;
      weight_wr_idx  = 4'(i);
      weight_wr_data = wd;
    end
    e.i = 4'(i);
    e.d = dm(mp[i], k_m);
    e.w = mw[i];
    q.push_back(e);
    @(posedge clk); #1;
    out_ready    = 1'b0;
    weight_wr_en = 1'b0;
    mp[i]       = fp[i];
    shadow_m[i] = sp[i];
`ifdef POTENTIAL_DECAY_WEIGHT_CLEAR_EN
    mw[i] = '0;
`endif
    if (wr) mw[i] = wd;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, sweep_done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, expected 000", {out_valid, busy, sweep_done});
    end
    checks++;
    if ({spike_vector, neuron_idx, decayed, weight} !== '0) begin
      failures++;
      $display("FAIL reset_data: got spk=%b idx=%0d pot=%h w=%h, expected all 0",
               spike_vector, neuron_idx, decayed, weight);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    begin_sweep(3'd0);
    checks++;
    if ({busy, out_valid, neuron_idx} !== {2'b11, 4'd0}) begin
      failures++;
      $display("FAIL first_issue: got busy=%b valid=%b idx=%0d, expected 1 1 0",
               busy, out_valid, neuron_idx);
    end
    for (int i = 0; i < 10; i++) hs_step(i, 1'b0, '0);
    checks++;
    if ({sweep_done, busy, out_valid} !== 3'b110) begin
      failures++;
      $display("FAIL done_pulse1: got %b, expected 110", {sweep_done, busy, out_valid});
    end
    @(posedge clk); #1;
    spk_m = shadow_m;
    checks++;
    if ({spike_vector, sweep_done, busy} !== {spk_m, 2'b00}) begin
      failures++;
      $display("FAIL sweep_end1: got spk=%b done=%b busy=%b, expected spk=%b 0 0",
               spike_vector, sweep_done, busy, spk_m);
    end
    begin_sweep(3'd1);
    checks++;
    if (decayed !== 32'h3F00_0000 || neuron_idx !== 4'd0) begin
      failures++;
      $display("FAIL half_of_one: got pot=%h idx=%0d, expected 3f000000 idx 0",
               decayed, neuron_idx);
    end
    for (int i = 0; i < 10; i++) hs_step(i, 1'b0, '0);
    checks++;
    if (sweep_done !== 1'b1) begin
      failures++;
      $display("FAIL done_pulse2: got %b, expected 1", sweep_done);
    end
    @(posedge clk); #1;
    spk_m = shadow_m;
    checks++;
    if (spike_vector !== spk_m || sweep_done !== 1'b0) begin
      failures++;
      $display("FAIL sweep_end2: got spk=%b done=%b, expected %b 0",
               spike_vector, sweep_done, spk_m);
    end
  endtask

  task automatic test_decay_edges;
    begin_sweep(3'd2);
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin
        checks++;
        if (decayed !== 32'h0) begin
          failures++;
          $display("FAIL flush_e1: got %h, expected 00000000", decayed);
        end
      end
      if (i == 2) begin
        checks++;
        if (decayed !== 32'h7F80_0000) begin
          failures++;
          $display("FAIL inf_pass: got %h, expected 7f800000", decayed);
        end
      end
      if (i == 4) begin
        checks++;
        if (decayed !== 32'hBE80_0000) begin
          failures++;
          $display("FAIL neg_decay: got %h, expected be800000", decayed);
        end
      end
      hs_step(i, 1'b0, '0);
    end
    @(posedge clk); #1;
    spk_m = shadow_m;
    checks++;
    if (spike_vector !== spk_m) begin
      failures++;
      $display("FAIL sweep_end3: got %b, expected %b", spike_vector, spk_m);
    end
  endtask

  task automatic test_weight;
    wr_weight(4'd3, 32'h4000_0000);
    wr_weight(4'd12, 32'hDEAD_BEEF);
    sp = 10'b00_0000_1000;
    begin_sweep(3'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        checks++;
        if (weight !== 32'h4000_0000 || neuron_idx !== 4'd3) begin
          failures++;
          $display("FAIL weight3: got w=%h idx=%0d, expected 40000000 idx 3",
                   weight, neuron_idx);
        end
      end
      hs_step(i, i == 5, 32'h1234_5678);
    end
    @(posedge clk); #1;
    spk_m = shadow_m;
    checks++;
    if (spike_vector !== 10'b00_0000_1000) begin
      failures++;
      $display("FAIL spike3: got %b, expected 0000001000", spike_vector);
    end
  endtask

  task automatic test_stall;
    logic [31:0] pot0;
    sp = 10'b10_0101_0011;
    begin_sweep(3'd1);
    for (int i = 0; i < 4; i++) hs_step(i, 1'b0, '0);
    pot0 = dm(mp[4], k_m);
    for (int c = 0; c < 5; c++) begin
      final_potential_in = $urandom;
      spike_in           = 1'b1;
      if (c == 2) begin
        start       = 1'b1;
        decay_shift = 3'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({neuron_idx, out_valid, busy, decayed, weight} !==
          {4'd4, 2'b11, pot0, mw[4]}) begin
        failures++;
        $display("FAIL stall_c%0d: got idx=%0d v=%b b=%b pot=%h w=%h, expected 4 1 1 %h %h",
                 c, neuron_idx, out_valid, busy, decayed, weight, pot0, mw[4]);
      end
    end
    for (int i = 4; i < 10; i++) hs_step(i, 1'b0, '0);
    checks++;
    if (sweep_done !== 1'b1) begin
      failures++;
      $display("FAIL stall_done: got %b, expected 1", sweep_done);
    end
    @(posedge clk); #1;
    spk_m = shadow_m;
    checks++;
    if (spike_vector !== spk_m) begin
      failures++;
      $display("FAIL stall_spk: got %b, expected %b", spike_vector, spk_m);
    end
  endtask

  task automatic test_clear;
    logic [31:0] exp_w;
`ifdef POTENTIAL_DECAY_WEIGHT_CLEAR_EN
    exp_w = 32'h0;
`else
    exp_w = 32'h3F80_0000;
`endif
    wr_weight(4'd0, 32'h3F80_0000);
    begin_sweep(3'd0);
    checks++;
    if (weight !== 32'h3F80_0000) begin
      failures++;
      $display("FAIL clear_first: got %h, expected 3f800000", weight);
    end
    for (int i = 0; i < 10; i++) hs_step(i, 1'b0, '0);
    @(posedge clk); #1;
    spk_m = shadow_m;
    begin_sweep(3'd0);
    checks++;
    if (weight !== exp_w) begin
      failures++;
      $display("FAIL clear_second: got %h, expected %h", weight, exp_w);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        checks++;
        if (decayed !== 32'h4120_0000) begin
          failures++;
          $display("FAIL pmem3: got %h, expected 41200000", decayed);
        end
      end
      hs_step(i, 1'b0, '0);
    end
    @(posedge clk); #1;
    spk_m = shadow_m;
    checks++;
    if (spike_vector !== spk_m) begin
      failures++;
      $display("FAIL clear_spk: got %b, expected %b", spike_vector, spk_m);
    end
  endtask

  task automatic test_mid_reset;
    begin_sweep(3'd3);
    for (int i = 0; i < 6; i++) hs_step(i, 1'b0, '0);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, sweep_done} !== 3'b000) begin
      failures++;
      $display("FAIL async_rst: got %b, expected 000", {out_valid, busy, sweep_done});
    end
    checks++;
    if ({neuron_idx, decayed, weight, spike_vector} !== '0) begin
      failures++;
      $display("FAIL rst_mem: got idx=%0d pot=%h w=%h spk=%b, expected all 0",
               neuron_idx, decayed, weight, spike_vector);
    end
    for (int i = 0; i < 10; i++) begin
      mp[i] = '0;
      mw[i] = '0;
    end
    shadow_m = '0;
    spk_m    = '0;
    k_m      = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    begin_sweep(3'd2);
    checks++;
    if ({out_valid, neuron_idx} !== {1'b1, 4'd0}) begin
      failures++;
      $display("FAIL restart: got v=%b idx=%0d, expected 1 0", out_valid, neuron_idx);
    end
    for (int i = 0; i < 10; i++) hs_step(i, 1'b0, '0);
    @(posedge clk); #1;
    spk_m = shadow_m;
    checks++;
    if (spike_vector !== spk_m) begin
      failures++;
      $display("FAIL restart_spk: got %b, expected %b", spike_vector, spk_m);
    end
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    rst                = 1'b1;
    start              = 1'b0;
    decay_shift        = '0;
    weight_wr_en       = 1'b0;
    weight_wr_idx      = '0;
    weight_wr_data     = '0;
    out_ready          = 1'b0;
    final_potential_in = '0;
    spike_in           = 1'b0;
    k_m                = '0;
    shadow_m           = '0;
    spk_m              = '0;
    sp                 = 10'b10_1000_0101;
    for (int i = 0; i < 10; i++) begin
      mp[i] = '0;
      mw[i] = '0;
    end
    fp[0] = 32'h3F80_0000;
    fp[1] = 32'h0080_0000;
    fp[2] = 32'h7F80_0000;
    fp[3] = 32'h4120_0000;
    fp[4] = 32'hBF80_0000;
    fp[5] = 32'h0000_0001;
    fp[6] = 32'h7FC0_0000;
    fp[7] = 32'h0100_0000;
    fp[8] = 32'h3F80_0000;
    fp[9] = 32'hC2C8_0000;
    test_reset();
    test_basic();
    test_decay_edges();
    test_weight();
    test_stall();
    test_clear();
    test_mid_reset();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/potential_decay.md
POTENTIAL_DECAY -- requirements
Module: potential_decay

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, listed first.
REQ-002 CLK_Decay  input  1  rising-edge clock for all state.
REQ-003 RST_Decay  input  1  asynchronous reset, active-high.
REQ-004 start  input  1  one-cycle pulse; begins a timestep sweep over neurons 0..9.
REQ-005 decay_shift  input  3  decay exponent k; the potential is multiplied by 2^-k. Sampled on the start cycle.
REQ-006 weight_wr_en, weight_wr_idx[3:0], weight_wr_data[31:0]  input  write of the IEEE-754 input weight for one neuron; indices above 9 are ignored.
REQ-007 input_weightDecay  output  32  weight of the neuron currently issued, to the adder's input_weight.
REQ-008 decayed_potentialDecay  output  32  decayed potential of the neuron currently issued, to the adder's decayed_potential.
REQ-009 neuron_idx  output  4  index of the neuron currently issued.
REQ-010 out_valid  output  1, out_ready  input  1  issue handshake; transfer occurs when both are 1.
REQ-011 final_potential_in  input  32, spike_in  input  1  adder results, valid in the handshake cycle.
REQ-012 spike_vector  output  10  registered spikes of the last completed sweep; bit i belongs to neuron i.
REQ-013 busy  output  1 and sweep_done  output  1  sweep in progress, and a one-cycle completion pulse.

Function
REQ-014 State: potential memory pmem[0..9] and weight memory wmem[0..9], each 32 bits.
REQ-015 FSM states: IDLE, ISSUE, DONE.
  - IDLE -> ISSUE on start, with idx=0 and k latched.
  - ISSUE -> DONE on a handshake at idx=9.
  - DONE -> IDLE after exactly one cycle.
REQ-016 In ISSUE, out_valid=1. decayed_potentialDecay and input_weightDecay SHALL be combinational from pmem[idx] and wmem[idx].
REQ-017 Zero-latency handshake: in the handshake cycle, the block writes final_potential_in into pmem[idx], writes spike_in into a shadow spike register bit idx, and increments idx.
REQ-018 With out_ready=0, all outputs SHALL hold stable and no memory SHALL change.
REQ-019 Decay rule on value V with exponent E=V[30:23]:
  - k=0: output V.
  - E=255: output V unchanged (inf/NaN).
  - E<=k: output 32'h00000000 (flush, includes denormals).
  - otherwise: output {V[31], E-k, V[22:0]}.
REQ-020 In DONE, sweep_done=1 and spike_vector SHALL load the shadow register. spike_vector holds until the next DONE.
REQ-021 busy=1 in ISSUE and DONE. start while busy SHALL be ignored.
REQ-022 A weight write SHALL take effect at the next edge in any state. If it targets the idx being handshaked, the new weight is stored and the feature in REQ-026 does not clear it.
REQ-023 The shadow spike register SHALL clear on the start edge.

Reset
REQ-024 Asserting RST_Decay SHALL immediately, including mid-sweep, drive:
  - FSM to IDLE, idx=0, k=0;
  - pmem, wmem, shadow register and spike_vector to 0;
  - out_valid=0, busy=0, sweep_done=0.
REQ-025 The first start after reset deassertion SHALL be honoured.

Configuration
REQ-026 Macro POTENTIAL_DECAY_WEIGHT_CLEAR_EN:
  - Defined: wmem[idx] SHALL be zeroed in its handshake cycle, so a weight is consumed once.
  - Undefined: weights persist until overwritten.

Verification
REQ-027 pmem[0]=3F800000, k=1, start, out_ready=1 -> decayed_potentialDecay=3F000000 at neuron_idx 0. Ten handshakes on consecutive cycles, then sweep_done one cycle later.
REQ-028 Write weight 40000000 to neuron 3, sweep with final_potential_in=41200000 and spike_in=1 at idx 3 -> input_weightDecay=40000000 at idx 3, pmem[3]=41200000, spike_vector=10'b0000001000.
REQ-029 pmem value 00800000 (E=1), k=2 -> output 00000000. Value 7F800000 -> output 7F800000.
REQ-030 out_ready held 0 for 5 cycles at idx 4 -> idx, outputs and memories stable. start pulsed mid-sweep has no effect.
REQ-031 Assert RST_Decay at idx 6 -> out_valid and busy drop asynchronously, memories read 0, next start sweeps from idx 0.
REQ-032 With POTENTIAL_DECAY_WEIGHT_CLEAR_EN defined, weight 3F800000 at neuron 0 -> the second sweep presents 00000000. Undefined -> the second sweep presents 3F800000.
